// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Bundle of the requester, response and shared-ALU signals of alu_arbiter.
//
// Handshake rule: a transfer happens on a rising clk edge where both valid
// and ready are high. A requester holds valid, a, b and op stable until
// it sees its ready bit. The arbiter holds rsp_valid, rsp_id and
// rsp_result stable until rsp_ready is high.
//
// Modports:
//   slave  - the arbiter side (takes requests, produces responses, drives ALU)
//   master - the requester/consumer/ALU side (testbench or surrounding logic)
//
// Signals:
//   req_valid[1:0]       per-requester operation valid
//   req_ready[1:0]       per-requester accept (one-hot or zero)
//   req_a/req_b          packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op[7:0]          packed op codes, requester i at [i*4 +: 4]
//   rsp_valid/rsp_ready  result handshake
//   rsp_id               owner of the result
//   rsp_result           registered ALU result
//   alu_operandA/B       shared ALU operands
//   alu_operation        shared ALU op select
//   alu_result           shared ALU output
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [7:0]         req_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_result;
    logic [WIDTH-1:0]   alu_operandA;
    logic [WIDTH-1:0]   alu_operandB;
    logic [3:0]         alu_operation;
    logic [WIDTH-1:0]   alu_result;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_result,
               alu_operandA, alu_operandB, alu_operation
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result,
               alu_operandA, alu_operandB, alu_operation
    );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. A round-robin grant
// is made in IDLE, the winner's operands are latched (EXEC), the ALU output
// is registered and presented as a response (RESP) until accepted.
// One operation is in flight at a time; peak rate is one per three cycles.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus          alu_arbiter_if.slave (requests, response, shared ALU)
//   dbg_state_o  current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//   stat_grant0  saturating grant count, requester 0 (ALU_ARB_STATS_EN only)
//   stat_grant1  saturating grant count, requester 1 (ALU_ARB_STATS_EN only)
//
// Build option: define ALU_ARB_STATS_EN to add the grant statistics ports.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus,
    output logic [1:0]  dbg_state_o
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] stat_grant0,
    output logic [15:0] stat_grant1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;       // index of the most recent grant
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             id_q;
    logic [WIDTH-1:0] result_q;
    logic             rsp_valid_q;

    logic             grant_vld;
    logic             grant_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_op;

    // Grant decision. Under contention the requester not served last wins.
    // Gated by rst so req_ready reads zero while reset is held.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (bus.req_valid == 2'b11) begin
                grant_vld = 1'b1;
                grant_idx = ~last_q;
            end else if (bus.req_valid[0]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end else if (bus.req_valid[1]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    assign sel_a  = grant_idx ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    assign sel_b  = grant_idx ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
    assign sel_op = grant_idx ? bus.req_op[7:4] : bus.req_op[3:0];

    assign bus.req_ready     = grant_vld ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign bus.alu_operandA  = a_q;
    assign bus.alu_operandB  = b_q;
    assign bus.alu_operation = op_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = id_q;
    assign bus.rsp_result    = result_q;
    assign dbg_state_o       = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;    // requester 0 wins the first contention
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            result_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        op_q    <= sel_op;
                        id_q    <= grant_idx;
                        last_q  <= grant_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= bus.alu_result;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat0_q;
    logic [15:0] stat1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else if (grant_vld) begin
            if (!grant_idx && stat0_q != 16'hFFFF) begin
                stat0_q <= stat0_q + 16'd1;
            end
            if (grant_idx && stat1_q != 16'hFFFF) begin
                stat1_q <= stat1_q + 16'd1;
            end
        end
    end

    assign stat_grant0 = stat0_q;
    assign stat_grant1 = stat1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Bench for alu_arbiter. A transaction-level model tracks the one
// outstanding operation (granted -> executing -> responding), the last
// winner, and a queue of expected {id, result} pairs built from the
// requests as they are accepted.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    localparam int W = 32;

    logic clk;
    logic rst;
    logic [1:0] dbg_state;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_grant0;
    logic [15:0] stat_grant1;
`endif

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant0 (stat_grant0),
        .stat_grant1 (stat_grant1)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench ALU ----------------
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
        case (op)
            4'b0000: alu_fn = a + b;
            4'b1000: alu_fn = a - b;
            4'b0111: alu_fn = a & b;
            4'b0110: alu_fn = a | b;
            4'b0100: alu_fn = a ^ b;
            4'b0001: alu_fn = a << b[4:0];
            default: alu_fn = a;
        endcase
    endfunction

    always_comb bus.alu_result = alu_fn(bus.alu_operandA, bus.alu_operandB, bus.alu_operation);

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    logic [W:0]  exp_q[$];      // {id, result}
    int          served_ids[$];
    logic [W-1:0] last_rsp_result;
    int          rsp_count;
    int          stage;         // 0 none outstanding, 1 executing, 2 responding
    int          last_grant;
    logic [W-1:0] cur_a, cur_b;
    logic [3:0]  cur_op;

    // ---------------- requester state ----------------
    logic         pend_v[2];
    logic [W-1:0] pend_a[2];
    logic [W-1:0] pend_b[2];
    logic [3:0]   pend_op[2];
    logic         hold[2];
    int           refill_mode;  // 0 manual, 1 keep both valid, 2 random
    int           rdy_random;
    int           bp_left;

    task automatic new_op(input int i);
        pend_v[i]  = 1'b1;
        pend_a[i]  = $urandom;
        pend_b[i]  = $urandom;
        pend_op[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op);
        pend_v[i]  = 1'b1;
        pend_a[i]  = a;
        pend_b[i]  = b;
        pend_op[i] = op;
    endtask

    // One clock cycle: drive, check at negedge, advance the model.
    task automatic cycle();
        int winner;
        logic [1:0] vld;
        logic [1:0] exp_ready;
        for (int i = 0; i < 2; i++) begin
            if (!pend_v[i]) begin
                if (refill_mode == 1) new_op(i);
                else if (refill_mode == 2 && $urandom_range(0, 1) == 1) new_op(i);
            end
            hold[i] = (refill_mode == 2) && ($urandom_range(0, 3) == 0);
        end
        vld = {pend_v[1] & ~hold[1], pend_v[0] & ~hold[0]};
        bus.req_valid = vld;
        bus.req_a     = {pend_a[1], pend_a[0]};
        bus.req_b     = {pend_b[1], pend_b[0]};
        bus.req_op    = {pend_op[1], pend_op[0]};
        if (stage == 2 && bp_left > 0) begin
            bus.rsp_ready = 1'b0;
            bp_left--;
        end else if (rdy_random != 0) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
        end else begin
            bus.rsp_ready = 1'b1;
        end

        @(negedge clk);
        winner    = 0;
        exp_ready = 2'b00;
        if (stage == 0 && vld != 2'b00) begin
            if (vld == 2'b11) winner = 1 - last_grant;
            else              winner = vld[0] ? 0 : 1;
            exp_ready = (winner == 1) ? 2'b10 : 2'b01;
        end
        check("req_ready", bus.req_ready, exp_ready);
        check("rsp_valid", bus.rsp_valid, (stage == 2));
        if (stage != 0) begin
            check("alu_operandA", bus.alu_operandA, cur_a);
            check("alu_operandB", bus.alu_operandB, cur_b);
            check("alu_operation", bus.alu_operation, cur_op);
        end
        if (stage == 2 && exp_q.size() > 0) begin
            check("rsp_id", bus.rsp_id, exp_q[0][W]);
            check("rsp_result", bus.rsp_result, exp_q[0][W-1:0]);
        end

        if (exp_ready != 2'b00) begin
            cur_a  = pend_a[winner];
            cur_b  = pend_b[winner];
            cur_op = pend_op[winner];
            exp_q.push_back({1'(winner), alu_fn(cur_a, cur_b, cur_op)});
            last_grant     = winner;
            pend_v[winner] = 1'b0;
            stage          = 1;
        end else if (stage == 1) begin
            stage = 2;
        end else if (stage == 2 && bus.rsp_ready) begin
            served_ids.push_back(int'(exp_q[0][W]));
            last_rsp_result = exp_q[0][W-1:0];
            void'(exp_q.pop_front());
            rsp_count++;
            stage = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_ops(input int n);
        int target;
        int cycles;
        target = rsp_count + n;
        cycles = 0;
        while (rsp_count < target && cycles < 100 * n + 20) begin
            cycle();
            cycles++;
        end
        check("ops_completed", rsp_count, target);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Asserts reset mid-cycle (asynchronously), checks reset values, releases.
    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 2'b11;
        #2;
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_result", bus.rsp_result, '0);
        check("rst_rsp_id", bus.rsp_id, 1'b0);
        check("rst_alu_operandA", bus.alu_operandA, '0);
        check("rst_alu_operandB", bus.alu_operandB, '0);
        check("rst_alu_operation", bus.alu_operation, 4'd0);
`ifdef ALU_ARB_STATS_EN
        check("rst_stat_grant0", stat_grant0, 16'd0);
        check("rst_stat_grant1", stat_grant1, 16'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 2'b00;
        stage      = 0;
        last_grant = 1;
        exp_q.delete();
        served_ids.delete();
        pend_v[0]   = 1'b0;
        pend_v[1]   = 1'b0;
        refill_mode = 0;
        rdy_random  = 0;
        bp_left     = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        rsp_count     = 0;
        last_rsp_result = '0;
        for (int i = 0; i < 2; i++) begin
            pend_v[i] = 1'b0; pend_a[i] = '0; pend_b[i] = '0; pend_op[i] = '0; hold[i] = 1'b0;
        end
        cur_a = '0; cur_b = '0; cur_op = '0;
        @(posedge clk);
        #1;
        do_reset();

        // single request: 5 + 3 from requester 0
        set_op(0, 32'd5, 32'd3, 4'b0000);
        run_ops(1);
        check("single_result", last_rsp_result, 32'd8);
        check("single_id", served_ids[0], 0);

        // contention straight after reset
        do_reset();
        set_op(0, 32'd10, 32'd4, 4'b0000);
        set_op(1, 32'd5, 32'd3, 4'b1000);
        run_ops(2);
        check("contend_first_id", served_ids[0], 0);
        check("contend_second_id", served_ids[1], 1);
        check("contend_second_result", last_rsp_result, 32'd2);

        // backpressure: 5 cycles of rsp_ready low, other requester waiting
        do_reset();
        set_op(0, 32'h1234, 32'h0F0F, 4'b0111);
        run_ops(0);
        cycle();                    // grant
        set_op(1, 32'd9, 32'd1, 4'b0000);
        bp_left = 5;
        run_ops(2);
        check("bp_result", last_rsp_result, 32'd10);

        // round robin with both requesters always valid
        do_reset();
        refill_mode = 1;
        run_ops(6);
        for (int k = 0; k < 6; k++) check("rr_id", served_ids[k], k % 2);

        // reset while executing drops the operation
        do_reset();
        set_op(1, 32'd7, 32'd2, 4'b0000);
        cycle();                    // requester 1 granted, now executing
        do_reset();
        idle_cycles(4);
        check("midrst_no_rsp", rsp_count, rsp_count);
        set_op(0, 32'd1, 32'd1, 4'b0000);
        set_op(1, 32'd2, 32'd2, 4'b0000);
        run_ops(1);
        check("midrst_next_winner", served_ids[0], 0);
        run_ops(1);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        refill_mode = 1;
        run_ops(4);
        refill_mode = 0;
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        set_op(0, 32'd3, 32'd4, 4'b0000);
        run_ops(1);
        check("stat_grant0", stat_grant0, 16'd3);
        check("stat_grant1", stat_grant1, 16'd2);
`endif

        // randomized traffic with random holds and random rsp_ready
        do_reset();
        refill_mode = 2;
        rdy_random  = 1;
        run_ops(150);
        check("random_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
